// File: rtl/clk_div_bank.sv
// Bank of programmable clock-enable / divided-clock channels with shadowed
// configuration, a global realigning load strobe and a configuration-lock flag.
module clk_div_bank #(
    parameter int  NCH         = 4,
    parameter int  DIV_W       = 8,
    parameter int  DEF_DIV     = 10,
    parameter int  DEF_PHASE   = 0,
    parameter int  LOCK_CYCLES = 16,
    localparam int CH_W        = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int LCK_W       = $clog2(LOCK_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stdby,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_phase,
    input  logic             cfg_en,
    input  logic             load,
    output logic [NCH-1:0]   div_ce,
    output logic [NCH-1:0]   div_out,
    output logic             lock
);

    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
    localparam logic [LCK_W-1:0] L_MAX = LCK_W'(LOCK_CYCLES);

    logic [DIV_W-1:0] r_sh_div [NCH];
    logic [DIV_W-1:0] r_sh_ph  [NCH];
    logic [NCH-1:0]   r_sh_en;
    logic [DIV_W-1:0] r_div    [NCH];
    logic [DIV_W-1:0] r_ph     [NCH];
    logic [NCH-1:0]   r_en;
    logic             r_init;
    logic             r_stdby_q;
    logic [LCK_W-1:0] r_lock_cnt;
    logic             r_lock;

    logic [DIV_W-1:0] w_sh_div_nxt [NCH];
    logic [DIV_W-1:0] w_sh_ph_nxt  [NCH];
    logic [NCH-1:0]   w_sh_en_nxt;
    logic [LCK_W-1:0] w_lock_nxt;
    logic             w_wr_ok;
    logic             w_load;
    logic             w_realign;

    assign w_wr_ok   = cfg_we && ({1'b0, cfg_ch} < (CH_W + 1)'(NCH));
    assign w_load    = load && !stdby;
    // Every channel restarts together on reset release, load and standby exit.
    assign w_realign = !stdby && (r_init || load || r_stdby_q);

    always_comb begin
        // NOTE: defaults first, so every path assigns every bit and no latch is inferred.
        w_sh_div_nxt = r_sh_div;
        w_sh_ph_nxt  = r_sh_ph;
        w_sh_en_nxt  = r_sh_en;
        if (w_wr_ok) begin
            w_sh_div_nxt[cfg_ch] = cfg_div;
            w_sh_ph_nxt[cfg_ch]  = cfg_phase;
            w_sh_en_nxt[cfg_ch]  = cfg_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file is tiny and must power up to known defaults, so it is reset.
            for (int i = 0; i < NCH; i++) begin
                r_sh_div[i] <= DIV_W'(DEF_DIV);
                r_sh_ph[i]  <= DIV_W'(DEF_PHASE);
                r_div[i]    <= DIV_W'(DEF_DIV);
                r_ph[i]     <= DIV_W'(DEF_PHASE);
            end
            r_sh_en   <= '1;
            r_en      <= '1;
            r_init    <= 1'b1;
            r_stdby_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignment so all registers sample pre-edge values.
            r_sh_div <= w_sh_div_nxt;
            r_sh_ph  <= w_sh_ph_nxt;
            r_sh_en  <= w_sh_en_nxt;
            if (w_load) begin
                r_div <= w_sh_div_nxt;
                r_ph  <= w_sh_ph_nxt;
                r_en  <= w_sh_en_nxt;
            end
            r_init    <= 1'b0;
            r_stdby_q <= stdby;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DIV_W-1:0] w_div_a, w_ph_a, w_d, w_p, w_cnt_nxt;
        logic             w_en_a;
        logic [DIV_W:0]   w_diff, w_half;
        logic [DIV_W-1:0] r_cnt;
        logic             r_ce, r_out;

        // A load edge must already use the freshly loaded (write-through) values.
        assign w_div_a   = w_load ? w_sh_div_nxt[i] : r_div[i];
        assign w_ph_a    = w_load ? w_sh_ph_nxt[i]  : r_ph[i];
        assign w_en_a    = w_load ? w_sh_en_nxt[i]  : r_en[i];
        assign w_d       = (w_div_a == '0) ? ONE : w_div_a;
        assign w_p       = (w_ph_a > w_d - ONE) ? w_d - ONE : w_ph_a;
        assign w_cnt_nxt = (w_realign || r_cnt >= w_d - ONE) ? '0 : r_cnt + ONE;
        assign w_diff    = (w_cnt_nxt >= w_p) ? {1'b0, w_cnt_nxt - w_p}
                                              : {1'b0, w_cnt_nxt} + {1'b0, w_d} - {1'b0, w_p};
        assign w_half    = ({1'b0, w_d} + (DIV_W + 1)'(1)) >> 1;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
                r_ce  <= 1'b0;
                r_out <= 1'b0;
            end else if (stdby) begin
                r_ce  <= 1'b0;
                r_out <= 1'b0;
            end else if (!w_en_a) begin
                r_cnt <= '0;
                r_ce  <= 1'b0;
                r_out <= 1'b0;
            end else begin
                r_cnt <= w_cnt_nxt;
                r_ce  <= (w_cnt_nxt == w_p);
                r_out <= (w_diff < w_half);
            end
        end

        assign div_ce[i]  = r_ce;
        assign div_out[i] = r_out;
    end

    always_comb begin
        w_lock_nxt = r_lock_cnt;
        if (stdby || w_realign) begin
            w_lock_nxt = '0;
        end else if (r_lock_cnt != L_MAX) begin
            w_lock_nxt = r_lock_cnt + LCK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_cnt <= '0;
            r_lock     <= 1'b0;
        end else begin
            r_lock_cnt <= w_lock_nxt;
            r_lock     <= !stdby && (w_lock_nxt == L_MAX);
        end
    end

    assign lock = r_lock;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: a cycle-count model of the channel rules is
// compared every cycle, plus hand-computed literal checkpoints.
module tb_clk_div_bank;

    localparam int NCH  = 4;
    localparam int DW   = 8;
    localparam int LOCK = 16;

    logic          clk;
    logic          rst_n;
    logic          stdby, cfg_we, cfg_en, load;
    logic [1:0]    cfg_ch;
    logic [DW-1:0] cfg_div, cfg_phase;
    logic [NCH-1:0] div_ce, div_out;
    logic          lock;

    // Second instance with a 3-bit channel select to exercise out-of-range writes.
    logic          cfg_we6;
    logic [2:0]    cfg_ch6;
    logic [5:0]    ce6, out6;
    logic          lock6;

    int n_cmp = 0;
    int n_bad = 0;

    clk_div_bank #(.NCH(NCH), .DIV_W(DW), .DEF_DIV(10), .DEF_PHASE(0), .LOCK_CYCLES(LOCK)) dut (
        .clk(clk), .rst_n(rst_n), .stdby(stdby), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_en(cfg_en), .load(load),
        .div_ce(div_ce), .div_out(div_out), .lock(lock));

    clk_div_bank #(.NCH(6), .DIV_W(DW), .DEF_DIV(10), .DEF_PHASE(0), .LOCK_CYCLES(LOCK)) dut6 (
        .clk(clk), .rst_n(rst_n), .stdby(stdby), .cfg_we(cfg_we6), .cfg_ch(cfg_ch6),
        .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_en(cfg_en), .load(load),
        .div_ce(ce6), .div_out(out6), .lock(lock6));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: k counts cycles since the last realign; outputs follow from k, D, P.
    int m_sdiv [NCH], m_sph [NCH], m_adiv [NCH], m_aph [NCH];
    bit m_sen [NCH], m_aen [NCH];
    bit m_run, m_sb, m_psb;
    int m_k;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_sdiv[i] = 10; m_sph[i] = 0; m_sen[i] = 1;
                m_adiv[i] = 10; m_aph[i] = 0; m_aen[i] = 1;
            end
            m_run = 0; m_sb = 0; m_psb = 0; m_k = 0;
        end else begin
            bit realign;
            if (cfg_we && int'(cfg_ch) < NCH) begin
                m_sdiv[cfg_ch] = int'(cfg_div);
                m_sph[cfg_ch]  = int'(cfg_phase);
                m_sen[cfg_ch]  = cfg_en;
            end
            realign = !stdby && (!m_run || load || m_psb);
            if (load && !stdby) begin
                m_adiv = m_sdiv; m_aph = m_sph; m_aen = m_sen;
            end
            m_run = 1; m_psb = stdby; m_sb = stdby;
            if (!stdby) m_k = realign ? 0 : m_k + 1;
        end
    end

    function automatic logic [2*NCH:0] model_out();
        logic [NCH-1:0] ce, o;
        ce = '0; o = '0;
        for (int i = 0; i < NCH; i++) begin
            int d, p;
            d = (m_adiv[i] == 0) ? 1 : m_adiv[i];
            p = (m_aph[i] > d - 1) ? d - 1 : m_aph[i];
            if (rst_n && m_run && !m_sb && m_aen[i]) begin
                ce[i] = ((m_k % d) == p);
                o[i]  = ((((m_k - p) % d) + d) % d) < ((d + 1) / 2);
            end
        end
        return {ce, o, rst_n && m_run && !m_sb && (m_k >= LOCK)};
    endfunction

    initial forever begin
        @(negedge clk);
        check("model", 32'({div_ce, div_out, lock}), 32'(model_out()));
    end

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] ch, input int dv, input int ph, input logic en, input logic ld);
        cfg_we = 1'b1; cfg_ch = ch; cfg_div = DW'(dv); cfg_phase = DW'(ph); cfg_en = en; load = ld;
        adv(1);
        cfg_we = 1'b0; cfg_en = 1'b1; load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; stdby = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
        cfg_phase = '0; cfg_en = 1'b1; load = 1'b0; cfg_we6 = 1'b0; cfg_ch6 = '0;
        #1 rst_n = 1'b0;
        #1 check("rst_outs", 32'({div_ce, div_out, lock}), 32'h0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;

        // Defaults D=10 P=0.
        adv(1);  check("def_k0_ce", 32'(div_ce), 32'hF); check("def_k0_out", 32'(div_out), 32'hF);
        check("def_k0_lock", 32'(lock), 32'h0);
        adv(4);  check("def_k4_out", 32'(div_out), 32'hF); check("def_k4_ce", 32'(div_ce), 32'h0);
        adv(1);  check("def_k5_out", 32'(div_out), 32'h0);
        adv(5);  check("def_k10_ce", 32'(div_ce), 32'hF);
        adv(5);  check("def_k15_lock", 32'(lock), 32'h0);
        adv(1);  check("def_k16_lock", 32'(lock), 32'h1);

        // ch1 D=5 P=2.
        wr(2'd1, 5, 2, 1'b1, 1'b0);
        load = 1'b1; adv(1); load = 1'b0;
        check("c1_k0_ce", 32'(div_ce), 32'hD); check("c1_k0_out", 32'(div_out), 32'hD);
        check("c1_k0_lock", 32'(lock), 32'h0);
        adv(2);  check("c1_k2_ce", 32'(div_ce), 32'h2); check("c1_k2_out", 32'(div_out), 32'hF);
        adv(2);  check("c1_k4_out", 32'(div_out), 32'hF);
        adv(1);  check("c1_k5_out", 32'(div_out), 32'h0);
        adv(2);  check("c1_k7_ce", 32'(div_ce), 32'h2); check("c1_k7_out", 32'(div_out), 32'h2);
        adv(8);  check("c1_k15_lock", 32'(lock), 32'h0);
        adv(1);  check("c1_k16_lock", 32'(lock), 32'h1);

        // Shadow-only write, then write-through on load.
        wr(2'd2, 3, 0, 1'b1, 1'b0);
        adv(100);
        wr(2'd2, 4, 0, 1'b1, 1'b1);
        check("wt_k0_ce2", 32'(div_ce[2]), 32'h1);
        adv(3);  check("wt_k3_ce2", 32'(div_ce[2]), 32'h0);
        adv(1);  check("wt_k4_ce2", 32'(div_ce[2]), 32'h1);

        // Edge values: div 0, div 1, phase clamp.
        wr(2'd0, 0, 0, 1'b1, 1'b0);
        wr(2'd1, 1, 0, 1'b1, 1'b0);
        wr(2'd2, 4, 9, 1'b1, 1'b0);
        load = 1'b1; adv(1); load = 1'b0;
        check("edge_k0_ce", 32'(div_ce), 32'hB); check("edge_k0_out", 32'(div_out), 32'hF);
        adv(1);  check("edge_k1_out", 32'(div_out), 32'hB);
        adv(2);  check("edge_k3_ce", 32'(div_ce), 32'h7);
        adv(4);  check("edge_k7_ce", 32'(div_ce), 32'h7);
        adv(4);  check("edge_k11_ce", 32'(div_ce), 32'h7);

        // Channel enable.
        wr(2'd3, 10, 0, 1'b0, 1'b1);
        check("dis_ce3", 32'(div_ce[3]), 32'h0); check("dis_out3", 32'(div_out[3]), 32'h0);
        adv(10); check("dis_k10_ce3", 32'(div_ce[3]), 32'h0);
        wr(2'd3, 10, 0, 1'b1, 1'b1);
        check("en_k0_ce3", 32'(div_ce[3]), 32'h1); check("en_k0_out3", 32'(div_out[3]), 32'h1);

        // Load held high.
        load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adv(1);
            check("hold_ce", 32'(div_ce), 32'hB); check("hold_out", 32'(div_out), 32'hF);
        end
        load = 1'b0;

        // Standby with a shadow write and an ignored load.
        adv(3);
        stdby = 1'b1; adv(1);
        check("sb_outs", 32'({div_ce, div_out, lock}), 32'h0);
        wr(2'd3, 6, 0, 1'b1, 1'b1);
        adv(19);
        stdby = 1'b0; adv(1);
        check("sbx_k0_ce", 32'(div_ce), 32'hB);
        adv(6);  check("sbx_k6_ce3", 32'(div_ce[3]), 32'h0);
        adv(9);  check("sbx_k15_lock", 32'(lock), 32'h0);
        adv(1);  check("sbx_k16_lock", 32'(lock), 32'h1);
        load = 1'b1; adv(1); load = 1'b0;
        adv(6);  check("sbl_k6_ce3", 32'(div_ce[3]), 32'h1);

        // Asynchronous reset mid-run.
        adv(2);
        #1 rst_n = 1'b0;
        #1 check("arst_outs", 32'({div_ce, div_out, lock}), 32'h0);
        adv(1);
        rst_n = 1'b1;
        adv(1);  check("rr_k0_ce", 32'(div_ce), 32'hF);
        adv(5);  check("rr_k5_out", 32'(div_out), 32'h0);
        adv(5);  check("rr_k10_ce", 32'(div_ce), 32'hF);

        // Out-of-range channel on the 6-channel instance.
        cfg_we6 = 1'b1; cfg_ch6 = 3'd7; cfg_div = 8'd3; cfg_phase = 8'd0; load = 1'b1;
        adv(1);
        cfg_we6 = 1'b0; load = 1'b0;
        check("oor_k0_ce", 32'(ce6), 32'h3F);
        adv(3);  check("oor_k3_ce", 32'(ce6), 32'h0);
        adv(7);  check("oor_k10_ce", 32'(ce6), 32'h3F);

        adv(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
